// File: rtl/mem_dma_engine.sv
// Purpose : DMA initiator on the DataMemory port; copies a block (src->dst) or fills a block with one byte.
// Latency : copy N bytes = 3N+1 cycles start->done, fill N bytes = N+1, len=0 -> 1 cycle.
// Backpr. : none; start is accepted only in IDLE, abort cancels an active transfer on the next edge.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, op, src, dst, len,     launch request and transfer descriptor (captured on accepted start)
//   fill_val
//   abort                         cancel the active transfer
//   busy, done, aborted, count    status: port owned, normal-completion pulse, cancel pulse, bytes written
//   mem_read, mem_write,          DataMemory initiator side (rdata valid one cycle after mem_read)
//   mem_addr, mem_wdata, mem_rdata
module mem_dma_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  count,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_FILL = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, count_q;
  logic [DATA_W-1:0] fill_q, data_q;
  logic [ADDR_W-1:0] addr_q, addr_c;
  logic [DATA_W-1:0] wdata_q, wdata_c;
  logic              aborted_q;
  logic              count_inc;
  logic              last_byte;
  logic [ADDR_W-1:0] offset;

  // Offset truncates to the address width so src+i / dst+i wrap naturally.
  assign offset    = count_q[ADDR_W-1:0];
  assign last_byte = ((count_q + LEN_W'(1)) == len_q);

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    count_inc = 1'b0;
    // Address and write data hold their last driven values outside active cycles.
    addr_c    = addr_q;
    wdata_c   = wdata_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)  state_n = S_FIN;
          else if (op)    state_n = S_FILL;
          else            state_n = S_RD;
        end
      end
      S_RD: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        addr_c   = src_q + offset;
        state_n  = S_CAP;
      end
      S_CAP: begin
        busy    = 1'b1;
        state_n = S_WR;
      end
      S_WR: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        addr_c    = dst_q + offset;
        wdata_c   = data_q;
        count_inc = 1'b1;
        state_n   = last_byte ? S_FIN : S_RD;
      end
      S_FILL: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        addr_c    = dst_q + offset;
        wdata_c   = fill_q;
        count_inc = 1'b1;
        state_n   = last_byte ? S_FIN : S_FILL;
      end
      S_FIN: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Abort only redirects the next state; the write of this cycle still happens.
    if (busy && abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      data_q    <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_c;
      wdata_q   <= wdata_c;
      aborted_q <= busy & abort;
      if (state == S_IDLE && start) begin
        src_q   <= src;
        dst_q   <= dst;
        len_q   <= len;
        fill_q  <= fill_val;
        count_q <= '0;
      end else if (count_inc) begin
        count_q <= count_q + LEN_W'(1);
      end
      if (state == S_CAP) data_q <= mem_rdata;
    end
  end

  assign aborted   = aborted_q;
  assign count     = count_q;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_c;

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed bench for mem_dma_engine with a behavioural 256x8 synchronous-read memory.
module tb_mem_dma_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, op, abort;
  logic [7:0] src, dst, fill_val;
  logic [8:0] len;
  logic       busy, done, aborted, mem_read, mem_write;
  logic [8:0] count;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] rdata;

  logic [7:0] mem [0:255];
  logic       pre_we;
  logic [7:0] pre_addr, pre_dat;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0, ab_cnt = 0, both_cnt = 0, wr_cnt = 0;

  always #5 clk = ~clk;

  mem_dma_engine #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .dst(dst), .len(len),
    .fill_val(fill_val), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .count(count), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata)
  );

  // Synchronous-read memory: rdata valid the cycle after mem_read.
  always @(posedge clk) begin
    if (mem_read) rdata <= mem[mem_addr];
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (aborted) ab_cnt++;
    if (mem_read && mem_write) both_cnt++;
    if (mem_write) wr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic launch(input logic o, input logic [7:0] s, input logic [7:0] d,
                        input logic [8:0] l, input logic [7:0] f);
    start = 1'b1; op = o; src = s; dst = d; len = l; fill_val = f;
  endtask

  // Returns the cycle index (1 = first cycle after the start cycle) at which done
  // is seen, or 0 if it never appears within limit.
  task automatic wait_done(input int limit, input int inj_at, input int abort_at, output int cyc);
    cyc = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      abort = (k == abort_at);
      if (k == inj_at) begin
        start = 1'b1; op = 1'b1; dst = 8'h50; len = 9'd5; fill_val = 8'hEE;
      end else if (k == inj_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        cyc = k;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int cyc;
    int d0, w0, a0, bad;

    rst = 1'b1; start = 1'b0; op = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0; fill_val = '0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_count", count, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Copy 4 bytes 0x10.. -> 0x40..
    poke(8'h10, 8'hA0); poke(8'h11, 8'hA1); poke(8'h12, 8'hA2); poke(8'h13, 8'hA3);
    launch(1'b0, 8'h10, 8'h40, 9'd4, 8'h00);
    wait_done(50, 0, 0, cyc);
    chk("copy_latency", cyc, 13);
    chk("copy_count", count, 4);
    chk("copy_busy_at_done", busy, 0);
    chk("copy_m40", mem[8'h40], 8'hA0);
    chk("copy_m41", mem[8'h41], 8'hA1);
    chk("copy_m42", mem[8'h42], 8'hA2);
    chk("copy_m43", mem[8'h43], 8'hA3);
    @(negedge clk);

    // Fill with address wrap.
    poke(8'h02, 8'h77);
    launch(1'b1, 8'h00, 8'hFE, 9'd4, 8'h5A);
    wait_done(50, 0, 0, cyc);
    chk("fill_latency", cyc, 5);
    chk("fill_count", count, 4);
    chk("fill_mFE", mem[8'hFE], 8'h5A);
    chk("fill_mFF", mem[8'hFF], 8'h5A);
    chk("fill_m00", mem[8'h00], 8'h5A);
    chk("fill_m01", mem[8'h01], 8'h5A);
    chk("fill_m02_untouched", mem[8'h02], 8'h77);
    @(negedge clk);

    // len = 0: done next cycle, no writes.
    w0 = wr_cnt;
    launch(1'b1, 8'h00, 8'h60, 9'd0, 8'hFF);
    wait_done(20, 0, 0, cyc);
    chk("len0_latency", cyc, 1);
    @(negedge clk);
    chk("len0_no_write", wr_cnt - w0, 0);
    chk("len0_count", count, 0);

    // Second start mid-copy is ignored.
    poke(8'h20, 8'hC1); poke(8'h21, 8'hC2); poke(8'h52, 8'h99);
    launch(1'b0, 8'h20, 8'h50, 9'd2, 8'h00);
    wait_done(50, 3, 0, cyc);
    chk("busy_start_latency", cyc, 7);
    chk("busy_start_count", count, 2);
    chk("busy_start_m50", mem[8'h50], 8'hC1);
    chk("busy_start_m51", mem[8'h51], 8'hC2);
    chk("busy_start_m52", mem[8'h52], 8'h99);
    @(negedge clk);

    // Abort during the 3rd FILL cycle.
    poke(8'h83, 8'h33);
    d0 = done_cnt; a0 = ab_cnt;
    launch(1'b1, 8'h00, 8'h80, 9'd8, 8'h6B);
    wait_done(15, 0, 3, cyc);
    chk("abort_no_done_seen", cyc, 0);
    chk("abort_done_cnt", done_cnt - d0, 0);
    chk("abort_pulse_cnt", ab_cnt - a0, 1);
    chk("abort_count", count, 3);
    chk("abort_busy", busy, 0);
    chk("abort_m80", mem[8'h80], 8'h6B);
    chk("abort_m82", mem[8'h82], 8'h6B);
    chk("abort_m83", mem[8'h83], 8'h33);

    // Reset in the middle of a fill.
    launch(1'b1, 8'h00, 8'h90, 9'd10, 8'h11);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rstfill_write_before", mem_write, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstfill_write_after", mem_write, 0);
    chk("rstfill_busy_after", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full 256-byte in-place copy.
    for (int i = 0; i < 256; i++) poke(8'(i), 8'(i) ^ 8'h5C);
    d0 = done_cnt;
    launch(1'b0, 8'h00, 8'h00, 9'd256, 8'h00);
    wait_done(1000, 0, 0, cyc);
    chk("full_latency", cyc, 769);
    chk("full_count", count, 256);
    @(negedge clk);
    @(negedge clk);
    chk("full_done_pulses", done_cnt - d0, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[8'(i)] !== (8'(i) ^ 8'h5C)) bad++;
    chk("full_data_unchanged", bad, 0);

    chk("never_read_and_write", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
